hack_uart_tx_mmio: RTL and testbench



---
 rtl/hack_io_pkg.sv | 22 ++
 rtl/hack_sync_fifo.sv | 60 ++++++
 rtl/hack_uart_tx_mmio.sv | 152 +++++++++++++++
 tb/tb_hack_uart_tx_mmio.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_io_pkg.sv
// Shared constants and types for the Hack memory-mapped I/O blocks.
// Address map, status bit positions and the UART serialiser state type.
package hack_io_pkg;

    localparam logic [14:0] HACK_KBD_ADDR       = 15'h6000;
    localparam logic [14:0] HACK_UART_TX_ADDR   = 15'h6002;
    localparam logic [14:0] HACK_UART_STAT_ADDR = 15'h6003;

    localparam int STAT_FULL_BIT = 0;
    localparam int STAT_BUSY_BIT = 1;
    localparam int STAT_OVF_BIT  = 2;
    localparam int STAT_CNT_LSB  = 4;
    localparam int STAT_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/hack_sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when
// empty are ignored. DEPTH must be a power of two so pointers wrap freely.
module hack_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hack_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the Hack data-memory write port.
// Decodes a data and a status address, buffers bytes and serialises them.
module hack_uart_tx_mmio
    import hack_io_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [14:0] TX_ADDR      = HACK_UART_TX_ADDR,
    parameter logic [14:0] STATUS_ADDR  = HACK_UART_STAT_ADDR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        we,
    input  logic [14:0] ram_address,
    input  logic [15:0] cpu_out_m,
    output logic [15:0] status_out,
    output logic        status_hit,
    output logic        tx,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_q;
    logic          overflow;

    logic          tx_hit;
    logic          tx_wr;
    logic          stat_wr;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          baud_last;
    logic [15:0]   status_word;
    logic          unused_hi;

    assign tx_hit     = (ram_address == TX_ADDR);
    assign status_hit = (ram_address == STATUS_ADDR);
    assign tx_wr      = we && tx_hit;
    assign stat_wr    = we && status_hit;
    assign push       = tx_wr && !full;
    assign pop        = (state == IDLE) && !empty;
    assign baud_last  = (baud == BAUD_MAX);
    assign busy       = !empty || (state != IDLE);
    assign tx         = tx_q;
    assign unused_hi  = ^cpu_out_m[15:8];

    hack_sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (Clk),
        .reset(Reset),
        .push (push),
        .pop  (pop),
        .wdata(cpu_out_m[7:0]),
        .rdata(fifo_rdata),
        .full (full),
        .empty(empty),
        .count(fifo_count)
    );

    // Status word assembly, gated so it only drives the bus on a hit.
    always_comb begin
        status_word = '0;
        status_word[STAT_FULL_BIT] = full;
        status_word[STAT_BUSY_BIT] = busy;
        status_word[STAT_OVF_BIT]  = overflow;
        status_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
        status_out = status_hit ? status_word : '0;
    end

    // Sticky overflow: set by a write into a full FIFO, cleared by software.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            overflow <= 1'b0;
        end else if (tx_wr && full) begin
            overflow <= 1'b1;
        end else if (stat_wr && cpu_out_m[STAT_OVF_BIT]) begin
            overflow <= 1'b0;
        end
    end

    // Serialiser; tx is registered from the current state, one cycle behind.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shift <= fifo_rdata;
                        baud  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    tx_q <= shift[0];
                    if (baud_last) begin
                        baud  <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_uart_tx_mmio.sv
// Directed bench for hack_uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Each task drives one scenario and compares against hand-derived values.
module tb_hack_uart_tx_mmio;

    localparam logic [14:0] A_TX   = 15'h6002;
    localparam logic [14:0] A_STAT = 15'h6003;

    logic        Clk;
    logic        Reset;
    logic        we;
    logic [14:0] ram_address;
    logic [15:0] cpu_out_m;
    logic [15:0] status_out;
    logic        status_hit;
    logic        tx;
    logic        busy;

    int checks;
    int errors;
    int kk;
    int nframes;
    logic [7:0] frame_bytes [5];

    hack_uart_tx_mmio #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .we         (we),
        .ram_address(ram_address),
        .cpu_out_m  (cpu_out_m),
        .status_out (status_out),
        .status_hit (status_hit),
        .tx         (tx),
        .busy       (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expected tx k cycles after the first push edge: frames of 40 cycles
    // each, starting 2 cycles after the push, separated by one idle cycle.
    function automatic logic exp_tx(int k);
        int j;
        int off;
        logic [7:0] b;
        if (k < 2) return 1'b1;
        j   = (k - 2) / 41;
        off = (k - 2) % 41;
        if (j >= nframes) return 1'b1;
        b = frame_bytes[3'(j)];
        if (off < 4) return 1'b0;
        if (off < 36) return b[3'((off - 4) / 4)];
        return 1'b1;
    endfunction

    task automatic do_reset();
        Reset       = 1'b1;
        we          = 1'b0;
        ram_address = '0;
        cpu_out_m   = '0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic check_tx(int k);
        logic e;
        e = exp_tx(k);
        checks++;
        if (tx !== e) begin
            errors++;
            $display("FAIL tx k=%0d got %b exp %b", k, tx, e);
        end
    endtask

    task automatic test_reset();
        do_reset();
        ram_address = A_STAT;
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx got %b exp 1", tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
        checks++;
        if (status_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_status got %h exp 0000", status_out);
        end
        checks++;
        if (status_hit !== 1'b1) begin
            errors++;
            $display("FAIL reset_hit got %b exp 1", status_hit);
        end
    endtask

    task automatic test_single_frame();
        logic eb;
        do_reset();
        nframes        = 1;
        frame_bytes[0] = 8'h55;
        we          = 1'b1;
        ram_address = A_TX;
        cpu_out_m   = 16'h1255;
        tick();
        we          = 1'b0;
        ram_address = A_STAT;
        for (int k = 0; k <= 42; k++) begin
            check_tx(k);
            eb = (k <= 40);
            checks++;
            if (busy !== eb) begin
                errors++;
                $display("FAIL busy k=%0d got %b exp %b", k, busy, eb);
            end
            if (k == 10) begin
                checks++;
                if (status_out[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL stat_busy got %b exp 1", status_out[1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        nframes = 5;
        for (int i = 0; i < 5; i++) begin
            frame_bytes[i] = 8'(8'h41 + i);
        end
        we          = 1'b1;
        ram_address = A_TX;
        cpu_out_m   = 16'h7F41;
        tick();
        for (kk = 0; kk < 5; kk++) begin
            check_tx(kk);
            cpu_out_m = 16'(16'h0041 + kk + 1);
            tick();
        end
        check_tx(kk);
        we          = 1'b0;
        ram_address = A_STAT;
        #1;
        checks++;
        if (status_out !== 16'h0047) begin
            errors++;
            $display("FAIL ovf_status got %h exp 0047", status_out);
        end
    endtask

    task automatic test_clear_overflow();
        we          = 1'b1;
        ram_address = A_STAT;
        cpu_out_m   = 16'h0004;
        tick();
        kk = 6;
        we = 1'b0;
        #1;
        check_tx(kk);
        checks++;
        if (status_out !== 16'h0043) begin
            errors++;
            $display("FAIL clr_status got %h exp 0043", status_out);
        end
    endtask

    task automatic test_back_to_back();
        ram_address = '0;
        for (kk = 7; kk <= 217; kk++) begin
            tick();
            check_tx(kk);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        do_reset();
        nframes        = 1;
        frame_bytes[0] = 8'h5A;
        we          = 1'b1;
        ram_address = A_TX;
        cpu_out_m   = 16'h005A;
        tick();
        cpu_out_m = 16'h00C3;
        tick();
        we          = 1'b0;
        ram_address = A_STAT;
        for (int k = 1; k < 16; k++) begin
            check_tx(k);
            tick();
        end
        check_tx(16);
        checks++;
        if (status_out !== 16'h0012) begin
            errors++;
            $display("FAIL mid_status got %h exp 0012", status_out);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rst_tx got %b exp 1", tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %b exp 0", busy);
        end
        checks++;
        if (status_out !== 16'h0000) begin
            errors++;
            $display("FAIL rst_status got %h exp 0000", status_out);
        end
        Reset = 1'b0;
        lows  = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL rst_no_start got %0d lows exp 0", lows);
        end
    endtask

    task automatic test_ignored_writes();
        int lows;
        logic [14:0] addrs [3];
        addrs[0] = 15'h6000;
        addrs[1] = 15'h6001;
        addrs[2] = 15'h1234;
        do_reset();
        lows = 0;
        for (int i = 0; i < 3; i++) begin
            we          = 1'b1;
            ram_address = addrs[i];
            cpu_out_m   = 16'h00FF;
            tick();
            if (tx !== 1'b1) lows++;
        end
        we          = 1'b0;
        ram_address = A_TX;
        cpu_out_m   = 16'h0055;
        tick();
        ram_address = 15'h1234;
        #1;
        checks++;
        if (status_hit !== 1'b0 || status_out !== 16'h0000) begin
            errors++;
            $display("FAIL miss_addr got hit=%b st=%h exp 0/0000",
                     status_hit, status_out);
        end
        ram_address = A_STAT;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (status_out !== 16'h0000) begin
            errors++;
            $display("FAIL ign_status got %h exp 0000", status_out);
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL ign_tx got %0d lows exp 0", lows);
        end
    endtask

    task automatic test_status_decode();
        logic [7:0] bytes [4];
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        bytes[3] = 8'h44;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            we          = 1'b1;
            ram_address = A_TX;
            cpu_out_m   = {8'h00, bytes[i]};
            tick();
        end
        we          = 1'b0;
        ram_address = A_STAT;
        #1;
        checks++;
        if (status_hit !== 1'b1) begin
            errors++;
            $display("FAIL dec_hit got %b exp 1", status_hit);
        end
        checks++;
        if (status_out !== 16'h0032) begin
            errors++;
            $display("FAIL dec_status got %h exp 0032", status_out);
        end
        ram_address = A_TX;
        #1;
        checks++;
        if (status_hit !== 1'b0) begin
            errors++;
            $display("FAIL dec_nohit got %b exp 0", status_hit);
        end
        checks++;
        if (status_out !== 16'h0000) begin
            errors++;
            $display("FAIL dec_zero got %h exp 0000", status_out);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        nframes     = 0;
        Reset       = 1'b1;
        we          = 1'b0;
        ram_address = '0;
        cpu_out_m   = '0;
        for (int i = 0; i < 5; i++) frame_bytes[i] = '0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_clear_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_ignored_writes();
        test_status_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
